// File: rtl/switch_debounce_if.sv
// Switch bundle between the raw board switches, the debouncer and the lamp controller.
// The master side owns the raw switch levels; the slave side is the debouncer.
interface switch_debounce_if;
  logic       S1;
  logic       S2;
  logic       S3;
  logic       S1_db;
  logic       S2_db;
  logic       S3_db;
  logic [2:0] chg;
  logic       press;
  logic       parity;

  modport master (
    output S1, S2, S3,
    input  S1_db, S2_db, S3_db, chg, press, parity
  );

  modport slave (
    input  S1, S2, S3,
    output S1_db, S2_db, S3_db, chg, press, parity
  );
endinterface

// File: rtl/switch_debounce.sv
// Three-channel switch conditioner: 2-flop synchroniser plus a per-channel
// stability counter that accepts a new level after DB_MAX disagreeing samples.
module switch_debounce #(
  parameter int unsigned          DB_W   = 16,
  parameter logic [DB_W-1:0]      DB_MAX = 16'd50000
) (
  input  logic                clk,
  input  logic                rst_n,
  switch_debounce_if.slave    sw
);

  localparam logic [DB_W-1:0] CNT_ZERO = {DB_W{1'b0}};
  localparam logic [DB_W-1:0] CNT_ONE  = {{(DB_W-1){1'b0}}, 1'b1};
  localparam logic [DB_W-1:0] CNT_LAST = DB_MAX - CNT_ONE;

  function automatic logic parity3(input logic [2:0] v);
    return v[0] ^ v[1] ^ v[2];
  endfunction

  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      lvl_q,   lvl_d;
  logic [2:0]      chg_q,   chg_d;
  logic            press_q, press_d;
  logic [DB_W-1:0] cnt_q [3];
  logic [DB_W-1:0] cnt_d [3];

  // Next-state: synchroniser shift and per-channel stability filter.
  always_comb begin
    sync1_d = {sw.S3, sw.S2, sw.S1};
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    chg_d   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        // Terminal count: the new level has been stable long enough.
        lvl_d[i] = sync2_q[i];
        cnt_d[i] = CNT_ZERO;
        chg_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
    press_d = |chg_d;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      lvl_q   <= 3'b000;
      chg_q   <= 3'b000;
      press_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      chg_q   <= chg_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw.S1_db  = lvl_q[0];
  assign sw.S2_db  = lvl_q[1];
  assign sw.S3_db  = lvl_q[2];
  assign sw.chg    = chg_q;
  assign sw.press  = press_q;
  assign sw.parity = parity3(lvl_q);

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Three-channel switch conditioner sitting directly upstream of the lamp controller. It synchronises the raw board switches S1..S3 to `clk` and filters contact bounce with a per-channel stability counter. It drives clean levels `S1_db`..`S3_db` that connect straight to the lamp controller's S1..S3 inputs, plus a one-cycle `press` pulse whenever any filtered switch changes.

## Interface
- `DB_W`, 16: width of each per-channel stability counter.
- `DB_MAX`, 16'd50000: consecutive disagreeing synchronised samples required to accept a new level (1 ms at 50 MHz). Legal range 1 .. 2^DB_W−1.

- `clk`  input  1  system clock; all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `S1`, `S2`, `S3`  input  1 each  raw, asynchronous, bouncing switch levels.
- `S1_db`, `S2_db`, `S3_db`  output  1 each  debounced, registered switch levels.
- `chg`  output  3  per-channel one-cycle change pulse; bit0=S1, bit1=S2, bit2=S3.
- `press`  output  1  one-cycle pulse; OR of `chg`, registered.
- `parity`  output  1  `S1_db ^ S2_db ^ S3_db`, combinational from registered levels.

## Operation
- Per channel: 2-flop synchroniser `sync1 -> sync2`. Only `sync2` feeds the filter.
- Per channel: counter `cnt[DB_W-1:0]` and accepted level `lvl` (= `Sx_db`).
- Each cycle, per channel:
  - If `sync2 == lvl`: `cnt <= 0`, `chg[i] <= 0`.
  - Else if `cnt == DB_MAX-1`: `lvl <= sync2`, `cnt <= 0`, `chg[i] <= 1`.
  - Else: `cnt <= cnt + 1`, `chg[i] <= 0`.
- The counter never exceeds DB_MAX−1, so no wrap is possible. Any single agreeing sample clears the count.
- `press <= |next_chg`: it asserts in the same cycle as the `chg` bit(s). Simultaneous changes on several channels give one single-cycle `press`, with every involved `chg` bit set.
- Channels are fully independent. There is no cross-channel priority.
- `DB_MAX = 1`: the level is accepted on the first disagreeing `sync2` sample.
- There is no other state machine. Each channel is an implicit two-state machine:
  - STABLE (cnt=0) goes to COUNTING on a mismatch.
  - COUNTING goes back to STABLE on a match (no update) or on terminal count (update and pulse).

## Timing
- Reset (`rst_n` low, asynchronous) clears the following immediately:
  - sync1, sync2, cnt, lvl all to 0.
  - `S1_db`..`S3_db` = 0, `chg` = 0, `press` = 0, `parity` = 0.
- Reset release is synchronous in effect. The first update happens on the first rising edge with `rst_n` high.
- Latency: raw input changes before edge E and then holds. The output updates on edge E+1+DB_MAX:
  - 2 synchroniser edges, with the first count on edge E+2.
  - `chg`/`press` high for exactly the cycle following that edge.
- Reset asserted mid-count aborts the count. The channel restarts from 0 with `lvl`=0. A switch held high through reset is accepted DB_MAX+2 edges after release.
- A raw pulse whose synchronised width is ≤ DB_MAX−1 cycles produces no output change and no pulse.
- `parity` changes in the same cycle as `Sx_db`. The lamp controller sees a stable level; it never sees bounce.

## Test plan
All scenarios use DB_MAX=4, DB_W=4.
- Reset: hold `rst_n`=0 with S1..S3=1 → all outputs 0. Release; S1..S3 held 1 → all `Sx_db`=1 on edge 6 after release, `chg`=3'b111 and `press`=1 for one cycle, `parity`=1.
- Clean press: S2 rises before edge E, holds → `S2_db`=1 after edge E+5, `chg`=3'b010 for one cycle, `parity`=1. S2 falls → mirror behaviour, `S2_db`=0 after 6 edges.
- Bounce rejection: S1 toggles 1,0,1,0 every cycle for 12 cycles then settles at 1 → no `chg` during toggling. `S1_db`=1 exactly 6 edges after the final settle; exactly one `press`.
- Glitch: S3 high for 3 cycles, then low → `S3_db` stays 0, `chg`=0 throughout.
- Simultaneous: S1 and S3 rise on the same cycle → `chg`=3'b101 for one cycle, single `press` pulse, `parity`=0.
- Reset mid-count: S1 rises; assert `rst_n`=0 after 3 edges for 2 cycles → `S1_db` stays 0 throughout. After release, `S1_db`=1 on edge 6.
